// File: rtl/sqrt_pkg.sv
// Shared definitions for the square-root pipeline controller.
package sqrt_pkg;
  localparam int DEF_STAGES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;
endpackage

// File: rtl/sqrt_stage_valid.sv
// One pipeline valid bit: loads from upstream when this stage can accept,
// holds while downstream stalls, and clears on flush or reset.
module sqrt_stage_valid (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  input  logic v_in,
  input  logic rdy,
  input  logic rdy_nxt,
  output logic v,
  output logic v_nxt,
  output logic en
);
  logic v_q, v_d;

  always_comb begin
    en  = v_in & rdy & !flush & !reset;
    v_d = (flush | reset) ? 1'b0 : (en | (v_q & !rdy_nxt));
  end

  always_ff @(posedge clock) begin
    if (reset) v_q <= 1'b0;
    else       v_q <= v_d;
  end

  assign v     = v_q;
  assign v_nxt = v_d;
endmodule

// File: rtl/sqrt_pipe_ctrl.sv
// Valid/ready controller for the pipelined square-root datapath: per-stage
// load enables and clear strobes, entry/exit handshakes, drain and flush.
module sqrt_pipe_ctrl
  import sqrt_pkg::*;
#(
  parameter int STAGES = DEF_STAGES,
  parameter int CNT_W  = 3,
  parameter int OPS_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run_en,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [STAGES-1:0] stage_en,
  output logic [STAGES-1:0] stage_clr,
  output logic [CNT_W-1:0]  inflight,
  output logic [OPS_W-1:0]  ops_done,
  output logic [1:0]        state
);
  logic [STAGES-1:0] v, v_nxt;
  logic [STAGES:0]   rdy;
  logic              acc, hs;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [OPS_W-1:0]  ops_q, ops_d;
  logic [STAGES-1:0] clr_q, clr_d;

  // Ready ripples back from the sink so empty stages (bubbles) always fill.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) rdy[i] = !v[i] | rdy[i+1];
  end

  assign in_ready = rdy[0] & run_en & !flush & !reset &
                    ((state_q == ST_IDLE) | (state_q == ST_RUN));
  assign acc       = in_valid & in_ready;
  assign out_valid = v[STAGES-1];
  assign hs        = out_valid & out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stg
    logic v_in;
    if (i == 0) begin : g_first
      assign v_in = acc;
    end else begin : g_rest
      assign v_in = v[i-1];
    end
    sqrt_stage_valid u_vld (
      .clock   (clock),
      .reset   (reset),
      .flush   (flush),
      .v_in    (v_in),
      .rdy     (rdy[i]),
      .rdy_nxt (rdy[i+1]),
      .v       (v[i]),
      .v_nxt   (v_nxt[i]),
      .en      (stage_en[i])
    );
  end

  always_comb begin
    inflight_d = '0;
    for (int i = 0; i < STAGES; i++) inflight_d = inflight_d + CNT_W'(v_nxt[i]);
    ops_d = ops_q + {{(OPS_W-1){1'b0}}, hs};
    clr_d = {STAGES{flush}};

    state_d = state_q;
    if (flush) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (acc)                             state_d = ST_RUN;
          else if (!run_en && inflight_d != 0) state_d = ST_DRAIN;
        end
        ST_RUN: begin
          if (inflight_d == 0) state_d = ST_IDLE;
          else if (!run_en)    state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (inflight_d == 0) state_d = ST_IDLE;
          else if (run_en)     state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      inflight_q <= '0;
      ops_q      <= '0;
      clr_q      <= '1;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      ops_q      <= ops_d;
      clr_q      <= clr_d;
    end
  end

  assign stage_clr = clr_q;
  assign inflight  = inflight_q;
  assign ops_done  = ops_q;
  assign state     = state_q;
endmodule

// File: tb/tb_sqrt_pipe_ctrl.sv
// Scoreboard bench for sqrt_pipe_ctrl: accepted ops are queued with their
// accept cycle and retired on each output handshake.
module tb_sqrt_pipe_ctrl;
  localparam int S = 4;
  localparam int CW = 3;
  localparam int OW = 4;

  logic          clock = 1'b0;
  logic          reset, run_en, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [S-1:0]  stage_en, stage_clr;
  logic [CW-1:0] inflight;
  logic [OW-1:0] ops_done;
  logic [1:0]    state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int q[$];
  logic [OW-1:0] exp_ops = '0;
  logic prev_clr = 1'b1;
  logic strict   = 1'b0;

  sqrt_pipe_ctrl #(.STAGES(S), .CNT_W(CW), .OPS_W(OW)) dut (
    .clock(clock), .reset(reset), .run_en(run_en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .stage_en(stage_en), .stage_clr(stage_clr),
    .inflight(inflight), .ops_done(ops_done), .state(state)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard / invariant monitor
  always @(negedge clock) begin
    chk("clr", 32'(stage_clr), prev_clr ? 32'hF : 32'h0);
    chk("ops", 32'(ops_done), 32'(exp_ops));
    chk("infl", 32'(inflight), 32'(q.size()));
    prev_clr = reset | flush;
    if (reset) begin
      q.delete();
      exp_ops = '0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", 32'd1, 32'd0);
        else begin
          int a, lat;
          a   = q.pop_front();
          lat = cyc - a;
          if (strict) chk("lat", 32'(lat), 32'(S));
          else        chk("lat_min", 32'(lat >= S), 32'd1);
        end
        exp_ops = exp_ops + 1'b1;
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clock);
      if (q.size() == 0 && state == 2'd0 && inflight == 0 && !out_valid) ok = 1'b1;
    end
    chk(tag, 32'(ok), 32'd1);
    tick();
  endtask

  initial begin
    reset = 1'b1; run_en = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    @(negedge clock);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ovld", 32'(out_valid), 32'd0);
    chk("rst_en", 32'(stage_en), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b0;

    // Streaming: 10 ops back to back, fixed latency
    strict = 1'b1; run_en = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    tick();
    @(negedge clock);
    chk("stream_state", 32'(state), 32'd1);
    repeat (8) tick();
    tick();
    in_valid = 1'b0;
    wait_idle("stream_idle");
    chk("stream_ops", 32'(ops_done), 32'd10);
    strict = 1'b0;

    // Back-pressure: fill, stall 5 cycles, then release
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (4) tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("bp_rdy", 32'(in_ready), 32'd0);
      chk("bp_en", 32'(stage_en), 32'd0);
      chk("bp_infl", 32'(inflight), 32'd4);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clock);
    chk("bp_rel_rdy", 32'(in_ready), 32'd1);
    chk("bp_rel_en", 32'(stage_en), 32'hF);
    tick();
    in_valid = 1'b0;
    wait_idle("bp_idle");
    chk("bp_ops", 32'(ops_done), 32'd15);

    // Bubble collapse: ops two cycles apart under stall end up in stages 3,2
    out_ready = 1'b0; in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b1; tick();
    in_valid = 1'b0;
    repeat (5) tick();
    @(negedge clock);
    chk("bub_infl", 32'(inflight), 32'd2);
    chk("bub_ovld", 32'(out_valid), 32'd1);
    chk("bub_en", 32'(stage_en), 32'd0);
    tick();
    out_ready = 1'b1;
    @(negedge clock); chk("bub_o0", 32'(out_valid), 32'd1); tick();
    @(negedge clock); chk("bub_o1", 32'(out_valid), 32'd1); tick();
    @(negedge clock); chk("bub_o2", 32'(out_valid), 32'd0);
    wait_idle("bub_idle");
    chk("bub_ops", 32'(ops_done), 32'd1);

    // Drain: 3 in flight, run_en drops
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (3) tick();
    run_en = 1'b0;
    @(negedge clock);
    chk("drn_rdy", 32'(in_ready), 32'd0);
    tick();
    out_ready = 1'b1;
    @(negedge clock);
    chk("drn_state", 32'(state), 32'd2);
    chk("drn_rdy2", 32'(in_ready), 32'd0);
    wait_idle("drn_idle");
    @(negedge clock);
    chk("drn_ops", 32'(ops_done), 32'd4);
    chk("idle_norun_rdy", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0; run_en = 1'b1;

    // Flush collides with an incoming operand
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (3) tick();
    flush = 1'b1;
    @(negedge clock);
    chk("fl_rdy", 32'(in_ready), 32'd0);
    chk("fl_en", 32'(stage_en), 32'd0);
    chk("fl_ovld", 32'(out_valid), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    chk("fl_state", 32'(state), 32'd3);
    chk("fl_clr", 32'(stage_clr), 32'hF);
    chk("fl_infl", 32'(inflight), 32'd0);
    tick();
    @(negedge clock);
    chk("fl_idle", 32'(state), 32'd0);
    chk("fl_clr0", 32'(stage_clr), 32'd0);
    chk("fl_ops", 32'(ops_done), 32'd4);
    tick();

    // Reset mid-stream
    out_ready = 1'b1; in_valid = 1'b1;
    repeat (6) tick();
    reset = 1'b1;
    tick();
    @(negedge clock);
    chk("mrst_ops", 32'(ops_done), 32'd0);
    chk("mrst_infl", 32'(inflight), 32'd0);
    chk("mrst_ovld", 32'(out_valid), 32'd0);
    chk("mrst_state", 32'(state), 32'd0);
    chk("mrst_rdy", 32'(in_ready), 32'd0);
    chk("mrst_en", 32'(stage_en), 32'd0);
    tick();
    reset = 1'b0;

    // Counter wrap: 17 results with a 4-bit counter
    strict = 1'b1;
    repeat (17) tick();
    in_valid = 1'b0;
    wait_idle("wrap_idle");
    chk("wrap_ops", 32'(ops_done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
